// File: rtl/scdaq_readout_sequencer.sv
// scdaq_readout_sequencer: walks one SCDAQ frame sample by sample and buffers
// the samples in a small shift-register FIFO whose head drives the outputs directly.
module scdaq_readout_sequencer #(
    parameter int NSAMPLES     = 128,
    parameter int PRECISION    = 14,
    parameter int RDO_ADD_BLEN = 7,
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Start,
    output logic                    Busy,
    output logic [RDO_ADD_BLEN-1:0] RDO_Add,
    output logic                    RDO_Req,
    input  logic                    RDO_Ack,
    input  logic [PRECISION-1:0]    RDO_Q,
    output logic                    RDO_Done,
    output logic [PRECISION-1:0]    Out_Data,
    output logic                    Out_Valid,
    input  logic                    Out_Ready,
    output logic                    Out_Last,
    output logic                    Error,
    output logic                    Start_Dropped,
    output logic [15:0]             Frame_Count
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [RDO_ADD_BLEN-1:0] LAST_ADDR = RDO_ADD_BLEN'(NSAMPLES - 1);

    typedef enum logic [2:0] {IDLE, REQ, GAP, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [RDO_ADD_BLEN-1:0] addr_q, addr_d;
    logic [CW-1:0]           count_q, count_d, wr_idx;
    logic [TW-1:0]           to_q, to_d;
    logic [PRECISION:0]      fifo_q [FIFO_DEPTH];
    logic [PRECISION:0]      fifo_d [FIFO_DEPTH];
    logic [15:0]             fc_q, fc_d;
    logic                    req_q, req_d, valid_q, valid_d, busy_q, busy_d;
    logic                    done_q, done_d, err_q, err_d, drop_q, drop_d;
    logic                    push, pop, hit;

    always_comb begin
        push    = req_q && RDO_Ack;
        pop     = valid_q && Out_Ready;
        hit     = req_q && !RDO_Ack && to_q == TW'(TIMEOUT - 1);
        state_d = state_q;
        addr_d  = addr_q;
        fc_d    = fc_q;
        done_d  = 1'b0;
        err_d   = hit;
        drop_d  = Start && state_q != IDLE;
        // the wait counter only advances while a request is actually outstanding
        to_d    = (state_q != REQ || push || hit) ? '0 : to_q + TW'(req_q);
        case (state_q)
            IDLE: begin
                state_d = Start ? REQ : IDLE;
                addr_d  = Start ? '0 : addr_q;
            end
            REQ: begin
                if (hit) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (push) begin
                    state_d = addr_q == LAST_ADDR ? DRAIN : GAP;
                    addr_d  = addr_q == LAST_ADDR ? addr_q : addr_q + 1'b1;
                end
            end
            GAP: state_d = REQ;
            DRAIN: begin
                state_d = count_q == '0 ? DONE : DRAIN;
                done_d  = count_q == '0;
                fc_d    = count_q == '0 ? fc_q + 16'd1 : fc_q;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // head lives in entry 0; vacated slots are zero-filled so a stale last tag never surfaces
        wr_idx = count_q - CW'(pop);
        for (int i = 0; i < FIFO_DEPTH; i++) fifo_d[i] = fifo_q[i];
        if (pop) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) fifo_d[i] = fifo_q[i + 1];
            fifo_d[FIFO_DEPTH - 1] = '0;
        end
        for (int i = 0; i < FIFO_DEPTH; i++)
            if (push && wr_idx == CW'(i)) fifo_d[i] = {RDO_Q, addr_q == LAST_ADDR};
        count_d = count_q + CW'(push) - CW'(pop);
        if (hit) begin
            count_d = '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_d[i] = '0;
        end
        req_d   = state_d == REQ && count_d < CW'(FIFO_DEPTH);
        valid_d = count_d != '0;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            to_q    <= '0;
            fc_q    <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            to_q    <= to_d;
            fc_q    <= fc_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= fifo_d[i];
        end
    end

    assign Busy          = busy_q;
    assign RDO_Add       = addr_q;
    assign RDO_Req       = req_q;
    assign RDO_Done      = done_q;
    assign Out_Data      = fifo_q[0][PRECISION:1];
    assign Out_Last      = fifo_q[0][0];
    assign Out_Valid     = valid_q;
    assign Error         = err_q;
    assign Start_Dropped = drop_q;
    assign Frame_Count   = fc_q;
endmodule

// File: tb/tb_scdaq_readout_sequencer.sv
// tb_scdaq_readout_sequencer: randomized SCDAQ/consumer traffic checked every cycle
// against a queue-based model of the readout rules, plus literal frame-level checks.
module tb_scdaq_readout_sequencer;
    localparam int N  = 128;
    localparam int P  = 14;
    localparam int AB = 7;
    localparam int D  = 4;
    localparam int TO = 255;
    localparam int S_IDLE = 0, S_REQ = 1, S_GAP = 2, S_DRAIN = 3, S_DONE = 4;

    logic Clock = 0, Reset = 1, Start = 0, RDO_Ack = 0, Out_Ready = 0;
    logic [P-1:0]  RDO_Q = '0;
    logic          Busy, RDO_Req, RDO_Done, Out_Valid, Out_Last, Error, Start_Dropped;
    logic [AB-1:0] RDO_Add;
    logic [P-1:0]  Out_Data;
    logic [15:0]   Frame_Count;

    scdaq_readout_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Busy(Busy),
        .RDO_Add(RDO_Add), .RDO_Req(RDO_Req), .RDO_Ack(RDO_Ack), .RDO_Q(RDO_Q),
        .RDO_Done(RDO_Done), .Out_Data(Out_Data), .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready), .Out_Last(Out_Last), .Error(Error),
        .Start_Dropped(Start_Dropped), .Frame_Count(Frame_Count)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SCDAQ responder and consumer, driven just after each rising edge
    int ack_mode = 0, no_ack_addr = -1;
    bit spur_en = 0, rnd_ready = 0, req_seen = 0;
    always @(posedge Clock) begin
        #1;
        RDO_Q = P'($urandom);
        if (RDO_Req)
            RDO_Ack = (int'(RDO_Add) == no_ack_addr) ? 1'b0 :
                      (ack_mode != 0) ? ($urandom_range(0, 2) != 0) : req_seen;
        else
            RDO_Ack = spur_en && $urandom_range(0, 2) == 0;
        req_seen = RDO_Req;
        if (rnd_ready) Out_Ready = $urandom_range(0, 3) != 0;
    end

    // model state: what the outputs must be during the current cycle
    typedef struct packed { logic [P-1:0] d; logic l; } ent_t;
    ent_t q[$];
    int m_phase = S_IDLE, m_addr = 0, m_wait = 0;
    logic [15:0] m_fc = '0;
    bit m_done = 0, m_err = 0, m_drop = 0;

    // frame-level monitors
    int rx_cnt = 0, rx_last = 0, last_idx = -1, hs_cnt = 0, ord_bad = 0;
    int done_seen = 0, err_seen = 0, drop_seen = 0;

    always @(negedge Clock) begin
        ent_t e;
        bit m_req, push, pop, was_empty;
        m_req = m_phase == S_REQ && q.size() < D;
        chk("Busy", Busy, m_phase != S_IDLE);
        chk("RDO_Req", RDO_Req, m_req);
        chk("RDO_Add", RDO_Add, m_addr);
        chk("RDO_Done", RDO_Done, m_done);
        chk("Error", Error, m_err);
        chk("Start_Dropped", Start_Dropped, m_drop);
        chk("Frame_Count", Frame_Count, m_fc);
        chk("Out_Valid", Out_Valid, q.size() != 0);
        chk("Out_Last", Out_Last, q.size() != 0 && q[0].l);
        if (q.size() != 0) chk("Out_Data", Out_Data, q[0].d);
        if (RDO_Req && RDO_Ack) begin
            if (int'(RDO_Add) != hs_cnt) ord_bad++;
            hs_cnt++;
        end
        if (Out_Valid && Out_Ready) begin
            if (Out_Last) begin rx_last++; last_idx = rx_cnt; end
            rx_cnt++;
        end
        if (RDO_Done) done_seen++;
        if (Error) err_seen++;
        if (Start_Dropped) drop_seen++;
        if (Reset) begin
            q.delete();
            m_phase = S_IDLE; m_addr = 0; m_wait = 0; m_fc = '0;
            m_done = 0; m_err = 0; m_drop = 0;
        end else begin
            push      = m_req && RDO_Ack;
            pop       = q.size() != 0 && Out_Ready;
            was_empty = q.size() == 0;
            m_drop    = Start && m_phase != S_IDLE;
            m_done    = 0;
            m_err     = 0;
            if (pop) void'(q.pop_front());
            if (push) begin
                e.d = RDO_Q;
                e.l = m_addr == N - 1;
                q.push_back(e);
            end
            m_wait = (m_phase == S_REQ && !push) ? m_wait + int'(m_req) : 0;
            case (m_phase)
                S_IDLE: if (Start) begin m_phase = S_REQ; m_addr = 0; end
                S_REQ:
                    if (m_wait == TO) begin
                        m_err = 1; m_done = 1; q.delete(); m_phase = S_IDLE; m_wait = 0;
                    end else if (push) begin
                        if (m_addr == N - 1) m_phase = S_DRAIN;
                        else begin m_addr++; m_phase = S_GAP; end
                    end
                S_GAP:   m_phase = S_REQ;
                S_DRAIN: if (was_empty) begin m_phase = S_DONE; m_done = 1; m_fc++; end
                S_DONE:  m_phase = S_IDLE;
                default: ;
            endcase
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin @(posedge Clock); #1; end
    endtask

    task automatic pulse_start();
        Start = 1; tick(); Start = 0;
    endtask

    task automatic clear_mon();
        rx_cnt = 0; rx_last = 0; last_idx = -1; hs_cnt = 0; ord_bad = 0;
        done_seen = 0; err_seen = 0; drop_seen = 0;
    endtask

    task automatic wait_idle(int lim);
        int k = 0;
        while (Busy && k < lim) begin tick(); k++; end
        chk("idle_within_budget", Busy, 0);
    endtask

    task automatic wait_addr(int a, int lim);
        int k = 0;
        while (!(RDO_Req && int'(RDO_Add) == a) && k < lim) begin tick(); k++; end
        chk("reach_addr", RDO_Add, a);
    endtask

    task automatic check_frame(string tag, int fc);
        chk({tag, "_samples"}, rx_cnt, N);
        chk({tag, "_last_count"}, rx_last, 1);
        chk({tag, "_last_index"}, last_idx, N - 1);
        chk({tag, "_handshakes"}, hs_cnt, N);
        chk({tag, "_addr_order_errs"}, ord_bad, 0);
        chk({tag, "_done_pulses"}, done_seen, 1);
        chk({tag, "_frame_count"}, Frame_Count, fc);
    endtask

    initial begin
        int lat;
        tick(3);
        chk("rst_busy", Busy, 0);
        chk("rst_req", RDO_Req, 0);
        chk("rst_valid", Out_Valid, 0);
        chk("rst_fc", Frame_Count, 0);
        Reset = 0;
        tick(2);

        // clean frame, one-cycle ack latency, consumer always ready
        Out_Ready = 1;
        clear_mon();
        pulse_start();
        wait_idle(3000);
        check_frame("f1", 1);

        // random acks, spurious acks, extra Start at addr 10, 50-cycle consumer stall
        ack_mode = 1; spur_en = 1;
        clear_mon();
        pulse_start();
        wait_addr(10, 2000);
        pulse_start();
        wait_addr(20, 2000);
        Out_Ready = 0;
        tick(50);
        chk("stall_req_low", RDO_Req, 0);
        chk("stall_valid", Out_Valid, 1);
        Out_Ready = 1;
        wait_idle(3000);
        check_frame("f2", 2);
        chk("f2_dropped", drop_seen, 1);

        // addr 5 never acknowledged
        ack_mode = 0; spur_en = 0; no_ack_addr = 5;
        clear_mon();
        pulse_start();
        wait_addr(5, 500);
        lat = 0;
        while (!Error && lat < 400) begin tick(); lat++; end
        chk("to_latency", lat, TO);
        chk("to_done_with_error", RDO_Done, 1);
        tick();
        chk("to_busy", Busy, 0);
        chk("to_valid", Out_Valid, 0);
        chk("to_fc", Frame_Count, 2);
        chk("to_err_pulses", err_seen, 1);
        no_ack_addr = -1;
        tick(3);

        // reset in the middle of a frame, then a fresh frame
        ack_mode = 1; spur_en = 1; rnd_ready = 1;
        pulse_start();
        wait_addr(60, 3000);
        Reset = 1; tick(); Reset = 0;
        chk("mid_rst_req", RDO_Req, 0);
        chk("mid_rst_valid", Out_Valid, 0);
        chk("mid_rst_busy", Busy, 0);
        chk("mid_rst_done", RDO_Done, 0);
        chk("mid_rst_fc", Frame_Count, 0);
        tick();
        clear_mon();
        pulse_start();
        wait_idle(4000);
        check_frame("f3", 1);

        // random frames with stray Start pulses
        for (int f = 0; f < 3; f++) begin
            int k = 0;
            ack_mode = $urandom_range(0, 1);
            clear_mon();
            pulse_start();
            while (Busy && k < 4000) begin
                Start = $urandom_range(0, 39) == 0;
                tick(); k++;
            end
            Start = 0;
            chk("rf_idle", Busy, 0);
            check_frame("rf", 2 + f);
        end
        rnd_ready = 0;
        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected under 3000000", $time);
        $fatal(1);
    end
endmodule
